// File: rtl/pll_ce_gen.sv
// pll_ce_gen: runtime-programmable phase-accumulator clock-enable generator with lock indication.
// Ports: refclk, rst (sync, active-high), cfg_we/cfg_ch/cfg_inc/cfg_phase write port,
//        ce[CHANNELS-1:0] enable pulses, locked; clkout[CHANNELS-1:0] when PLL_CE_CLKOUT_EN is defined.
module pll_ce_gen #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 32,
  parameter int SETTLE   = 16
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [ACC_W-1:0]    cfg_phase,
  output logic [CHANNELS-1:0] ce,
`ifdef PLL_CE_CLKOUT_EN
  output logic [CHANNELS-1:0] clkout,
`endif
  output logic                locked
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  localparam logic [15:0] SETTLE_M1 = 16'(SETTLE - 1);
  localparam logic [4:0]  NCH       = 5'(CHANNELS);

  state_t r_state;
  state_t w_state_nxt;

  logic [ACC_W-1:0] r_inc   [CHANNELS];
  logic [ACC_W-1:0] r_phase [CHANNELS];
  logic [ACC_W-1:0] r_acc   [CHANNELS];
  logic [ACC_W-1:0] w_acc_nxt [CHANNELS];
  logic [ACC_W:0]   w_sum   [CHANNELS];

  logic [CHANNELS-1:0] r_ce;
  logic [CHANNELS-1:0] w_ce_nxt;
  logic [15:0]         r_cnt;
  logic [15:0]         w_cnt_nxt;
  logic                w_wr_ok;
  logic                w_settled;

  // Writes to channel indices beyond CHANNELS are dropped entirely.
  assign w_wr_ok   = cfg_we && ({1'b0, cfg_ch} < NCH);
  assign w_settled = (r_cnt == SETTLE_M1);

  // Extra top bit of the sum is the wrap carry that becomes the pulse.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_sum
    assign w_sum[g] = {1'b0, r_acc[g]} + {1'b0, r_inc[g]};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ce_nxt    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_acc_nxt[i] = r_acc[i];
    end
    if (w_wr_ok) begin
      // Any write drops lock and kills pulses immediately.
      w_state_nxt = ST_UNLOCKED;
      w_cnt_nxt   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
        w_acc_nxt[i] = r_phase[i];
      end
    end else begin
      unique case (r_state)
        ST_UNLOCKED: begin
          w_cnt_nxt = r_cnt + 16'd1;
          if (w_settled) begin
            w_state_nxt = ST_RUN;
          end
          for (int i = 0; i < CHANNELS; i++) begin
            w_acc_nxt[i] = r_phase[i];
          end
        end
        ST_RUN: begin
          for (int i = 0; i < CHANNELS; i++) begin
            w_acc_nxt[i] = w_sum[i][ACC_W-1:0];
            w_ce_nxt[i]  = w_sum[i][ACC_W];
          end
        end
        default: begin
          w_state_nxt = ST_UNLOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= ST_UNLOCKED;
      r_cnt   <= '0;
      r_ce    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ce    <= w_ce_nxt;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_inc[i]   <= '0;
        r_phase[i] <= '0;
        r_acc[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= w_acc_nxt[i];
        if (w_wr_ok && (cfg_ch == 4'(i))) begin
          r_inc[i]   <= cfg_inc;
          r_phase[i] <= cfg_phase;
        end
      end
    end
  end

`ifdef PLL_CE_CLKOUT_EN
  logic [CHANNELS-1:0] r_clkout;

  // Square wave follows the accumulator MSB, gated low whenever unlocked.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_clkout <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_clkout[i] <= w_acc_nxt[i][ACC_W-1] & (w_state_nxt == ST_RUN);
      end
    end
  end

  assign clkout = r_clkout;
`endif

  assign ce     = r_ce;
  assign locked = (r_state == ST_RUN);

endmodule

// File: tb/tb_pll_ce_gen.sv
// tb_pll_ce_gen: scoreboard bench for pll_ce_gen (ACC_W=8, CHANNELS=2, SETTLE=16).
// Expected outputs are queued as each cycle is driven and compared after the edge.
module tb_pll_ce_gen;

  localparam int CH = 2;
  localparam int AW = 8;
  localparam int ST = 16;

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [3:0]    cfg_ch;
  logic [AW-1:0] cfg_inc;
  logic [AW-1:0] cfg_phase;
  logic [CH-1:0] ce;
  logic          locked;
`ifdef PLL_CE_CLKOUT_EN
  logic [CH-1:0] clkout;
`endif

  pll_ce_gen #(
    .CHANNELS(CH),
    .ACC_W(AW),
    .SETTLE(ST)
  ) u_dut (
    .refclk(refclk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc),
    .cfg_phase(cfg_phase),
    .ce(ce),
`ifdef PLL_CE_CLKOUT_EN
    .clkout(clkout),
`endif
    .locked(locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int lk;
    int ce0;
    int ce1;
    int ck0;
    int ck1;
  } exp_t;

  exp_t q[$];

  int n_run  = 0;
  int n_fail = 0;

  int m_inc [CH];
  int m_ph  [CH];
  int m_acc [CH];
  int m_ce  [CH];
  int m_cnt;
  int m_lock;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour for one rising edge with the given inputs.
  task automatic model_edge(input int r, input int we, input int ch,
                            input int inc, input int ph);
    if (r != 0) begin
      for (int i = 0; i < CH; i++) begin
        m_inc[i] = 0; m_ph[i] = 0; m_acc[i] = 0; m_ce[i] = 0;
      end
      m_cnt = 0;
      m_lock = 0;
    end else if (we != 0 && ch < CH) begin
      m_inc[ch] = inc;
      m_ph[ch]  = ph;
      m_cnt = 0;
      m_lock = 0;
      for (int i = 0; i < CH; i++) m_ce[i] = 0;
    end else if (m_lock == 0) begin
      for (int i = 0; i < CH; i++) begin
        m_acc[i] = m_ph[i];
        m_ce[i]  = 0;
      end
      m_lock = (m_cnt == ST - 1) ? 1 : 0;
      m_cnt  = m_cnt + 1;
    end else begin
      for (int i = 0; i < CH; i++) begin
        int s;
        s = m_acc[i] + m_inc[i];
        m_ce[i]  = (s >= 256) ? 1 : 0;
        m_acc[i] = s % 256;
      end
    end
  endtask

  task automatic step(input int r, input int we, input int ch,
                      input int inc, input int ph);
    exp_t e;
    rst       = (r != 0);
    cfg_we    = (we != 0);
    cfg_ch    = 4'(ch);
    cfg_inc   = AW'(inc);
    cfg_phase = AW'(ph);
    model_edge(r, we, ch, inc, ph);
    e.lk  = m_lock;
    e.ce0 = m_ce[0];
    e.ce1 = m_ce[1];
    e.ck0 = m_lock != 0 ? (m_acc[0] >> 7) : 0;
    e.ck1 = m_lock != 0 ? (m_acc[1] >> 7) : 0;
    q.push_back(e);
    @(posedge refclk);
    #1;
    e = q.pop_front();
    check("locked", int'(locked), e.lk);
    check("ce0", int'(ce[0]), e.ce0);
    check("ce1", int'(ce[1]), e.ce1);
`ifdef PLL_CE_CLKOUT_EN
    check("clkout0", int'(clkout[0]), e.ck0);
    check("clkout1", int'(clkout[1]), e.ck1);
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_lock(input string tag);
    int lat;
    lat = 0;
    for (int j = 1; j <= 100; j++) begin
      idle();
      if (locked === 1'b1) begin
        lat = j;
        break;
      end
    end
    check(tag, lat, ST);
  endtask

  task automatic measure(input int n, output int f0, output int f1,
                         output int c0, output int c1);
    f0 = -1; f1 = -1; c0 = 0; c1 = 0;
    for (int j = 1; j <= n; j++) begin
      idle();
      if (ce[0] === 1'b1) begin
        c0++;
        if (f0 < 0) f0 = j;
      end
      if (ce[1] === 1'b1) begin
        c1++;
        if (f1 < 0) f1 = j;
      end
    end
  endtask

  function automatic int first_k(input int ph, input int inc);
    return (256 - ph + inc - 1) / inc;
  endfunction

  int f0, f1, c0, c1;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
    for (int i = 0; i < CH; i++) begin
      m_inc[i] = 0; m_ph[i] = 0; m_acc[i] = 0; m_ce[i] = 0;
    end
    m_cnt = 0; m_lock = 0;
    @(posedge refclk);
    #1;

    // Reset, then settle with no writes: lock at edge 16, no pulses.
    step(1, 0, 0, 0, 0);
    check("rst_locked", int'(locked), 0);
    check("rst_ce", int'(ce), 0);
    wait_lock("lat_reset");
    measure(8, f0, f1, c0, c1);
    check("idle_cnt0", c0, 0);
    check("idle_cnt1", c1, 0);

    // Program both channels and check first-pulse offsets and rates.
    step(0, 1, 0, 'h80, 'h00);
    step(0, 1, 1, 'h40, 'hC0);
    wait_lock("lat_cfg");
    measure(16, f0, f1, c0, c1);
    check("first0", f0, first_k('h00, 'h80));
    check("first1", f1, first_k('hC0, 'h40));
    check("cnt0_16", c0, 8);
    check("cnt1_16", c1, 4);

    // Reconfigure in RUN: immediate drop, relock, realign.
    step(0, 1, 0, 'h80, 'h80);
    check("wr_drop_lock", int'(locked), 0);
    check("wr_drop_ce", int'(ce), 0);
    wait_lock("lat_rewr");
    measure(16, f0, f1, c0, c1);
    check("realign0", f0, first_k('h80, 'h80));
    check("realign1", f1, first_k('hC0, 'h40));
    check("re_cnt0", c0, 8);

    // Reset wins over a simultaneous write.
    step(1, 1, 0, 'h80, 'h00);
    wait_lock("lat_rstwr");
    measure(16, f0, f1, c0, c1);
    check("rstwr_cnt0", c0, 0);
    check("rstwr_cnt1", c1, 0);

    // Out-of-range channel write while running is ignored.
    step(0, 1, 0, 'h80, 'h00);
    wait_lock("lat_pre_inv");
    step(0, 1, CH, 'hFF, 'hFF);
    check("inv_locked", int'(locked), 1);
    measure(8, f0, f1, c0, c1);
    check("inv_cnt0", c0, 4);

    // Non-power-of-two ratio: exact average over 768 cycles.
    step(0, 1, 0, 'h55, 'h00);
    wait_lock("lat_55");
    measure(768, f0, f1, c0, c1);
    check("cnt_55", c0, 255);
    check("cnt_55_ch1", c1, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_ce_gen.md
# pll_ce_gen

Parametrised, runtime-programmable clock-enable generator with lock indication, for cores that need several derived rates from one fabric clock without a dedicated PLL output per rate. Each of CHANNELS channels is a phase accumulator producing single-cycle `ce` pulses at `f_refclk * inc / 2^ACC_W` with a programmable start phase. A settle counter drives `locked` after reset and after every reconfiguration. Sits directly downstream of the system PLL output clock.

## Interface

Parameters:
- `CHANNELS`, 2 — number of enable channels (1..16).
- `ACC_W`, 32 — accumulator / increment / phase width in bits (4..32).
- `SETTLE`, 16 — clock edges from reset/reconfig release to `locked` (1..65535).

Ports:
- `refclk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_we`  in  1  configuration write strobe, one cycle.
- `cfg_ch`  in  4  target channel index.
- `cfg_inc`  in  ACC_W  per-cycle increment for target channel.
- `cfg_phase`  in  ACC_W  start phase for target channel.
- `ce`  out  CHANNELS  per-channel clock-enable pulses, registered.
- `locked`  out  1  configuration settled; `ce` valid.

## Operation

- Per-channel state: `inc_r[i]`, `phase_r[i]`, `acc[i]` (all ACC_W bits); shared settle counter `cnt` (16 bits) and `locked`.
- Reset (`rst`=1 at an edge): `inc_r`, `phase_r`, `acc`, `cnt` <= 0; `ce` <= 0; `locked` <= 0. `rst` has priority over `cfg_we`; a write in the same cycle is discarded.
- Valid write (`cfg_we`=1, `cfg_ch` < CHANNELS): `inc_r[cfg_ch]` <= `cfg_inc`, `phase_r[cfg_ch]` <= `cfg_phase`; `cnt` <= 0, `locked` <= 0. Other channels' registers unchanged.
- Invalid write (`cfg_ch` >= CHANNELS): ignored entirely; `locked` and `cnt` unaffected.
- Settle: while `locked`=0 and no reset/write, `cnt` <= `cnt`+1 and `locked` <= (`cnt` == SETTLE-1). `locked` stays 1 until next reset or valid write.
- Two states per block: UNLOCKED (`locked`=0) and RUN (`locked`=1). UNLOCKED -> RUN on settle completion; RUN -> UNLOCKED on `rst` or valid write.
- UNLOCKED: every `acc[i]` <= `phase_r[i]` (all channels realign on any write); `ce` <= 0.
- RUN: `{carry, acc[i]}` <= `acc[i]` + `inc_r[i]` (ACC_W+1-bit sum, wraps modulo 2^ACC_W); `ce[i]` <= carry.
- `inc_r`=0: channel never pulses. `inc_r` >= 2^(ACC_W-1): pulses at least every other cycle; average rate exact, spacing jitters by one cycle for non-power-of-two ratios.

## Timing

- `locked` rises exactly SETTLE edges after the last edge sampling `rst`=1 or a valid write.
- Let t0 be the edge at which `locked` becomes 1. First `ce[i]` is high after edge t0+k, k = ceil((2^ACC_W - phase)/inc), for one cycle.
- Subsequent pulses: one-cycle width, mean period 2^ACC_W/inc cycles.
- Valid write: `locked` and all `ce` low from the next edge; no partial pulse emitted.
- Write while UNLOCKED restarts the settle count from 0.
- No combinational paths from inputs to outputs.

## Configuration

- `PLL_CE_CLKOUT_EN` defined: adds output `clkout` [CHANNELS-1:0] = registered MSB of `acc[i]` ANDed with `locked`; approximately 50% duty square wave at the channel rate, low while UNLOCKED, reset 0.
- Undefined: port and logic absent; `ce`/`locked` behaviour identical.

## Test plan

- Reset release, SETTLE=16, no writes -> `locked` rises at edge 16 after reset release; `ce` stays 0 (inc=0).
- ACC_W=8: write ch0 inc=0x80, phase=0 -> after lock, `ce[0]` high every 2nd cycle, first pulse after t0+2.
- ACC_W=8: ch1 inc=0x40, phase=0xC0 -> first `ce[1]` after t0+1, then every 4 cycles; ch0 unaffected in rate.
- Write in RUN -> `locked` and `ce` low next edge; relock after SETTLE; both channels realign to their phases.
- `rst` and `cfg_we` same cycle -> registers 0, write lost; `cfg_ch`=CHANNELS in RUN -> no change to `locked` or `ce`.
- ACC_W=8, inc=0x55 over 768 locked cycles -> exactly 255 `ce` pulses; with `PLL_CE_CLKOUT_EN`, `clkout` toggles with MSB, low while unlocked.
